// File: rtl/mmio_port_responder_pkg.sv
// Shared definitions for the MMIO port responder: register selects, byte
// offsets, STATUS bit positions and a STATUS packing helper.
package mmio_port_responder_pkg;

  // Register select taken from Address[3:2].
  typedef enum logic [1:0] {
    REG_PORT_OUT = 2'd0,
    REG_PORT_IN  = 2'd1,
    REG_STATUS   = 2'd2,
    REG_TX_DATA  = 2'd3
  } reg_sel_e;

  // Byte offsets inside the 16-byte window.
  localparam logic [3:0] OFF_PORT_OUT = 4'h0;
  localparam logic [3:0] OFF_PORT_IN  = 4'h4;
  localparam logic [3:0] OFF_STATUS   = 4'h8;
  localparam logic [3:0] OFF_TX_DATA  = 4'hC;

  // STATUS bit positions.
  localparam int unsigned ST_IN_CHANGED = 0;
  localparam int unsigned ST_FULL       = 1;
  localparam int unsigned ST_EMPTY      = 2;
  localparam int unsigned ST_OVERFLOW   = 3;
  localparam int unsigned ST_COUNT_LSB  = 4;

  // Assemble the STATUS word; count arrives zero-extended to 8 bits.
  function automatic logic [31:0] pack_status(input logic       in_changed,
                                              input logic       full,
                                              input logic       empty,
                                              input logic       overflow,
                                              input logic [7:0] count);
    logic [31:0] v;
    v                    = '0;
    v[ST_IN_CHANGED]     = in_changed;
    v[ST_FULL]           = full;
    v[ST_EMPTY]          = empty;
    v[ST_OVERFLOW]       = overflow;
    v[ST_COUNT_LSB +: 8] = count;
    return v;
  endfunction

endpackage

// File: rtl/mmio_port_responder_if.sv
// MIPS data-bus view seen by a memory-mapped responder.
//   Address/WriteData/MemWrite/MemRead : driven by the core (master)
//   ReadData                           : returned by the responder (slave)
interface mmio_port_responder_if;

  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] ReadData;

  modport master (
    output Address, WriteData, MemWrite, MemRead,
    input  ReadData
  );

  modport slave (
    input  Address, WriteData, MemWrite, MemRead,
    output ReadData
  );

endinterface

// File: rtl/mmio_port_responder_byte_fifo.sv
// Byte FIFO used as the TX queue: circular buffer with wrap-around pointers.
//   clk, reset (async, active-low)
//   push/din : enqueue din; ignored while full
//   pop      : dequeue head; ignored while empty
//   dout     : head byte (mem[rd_ptr])
//   full/empty/count : occupancy
module mmio_port_responder_byte_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [7:0]       din,
  input  logic             pop,
  output logic [7:0]       dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned AW = CNT_W - 1;

  logic [7:0]       r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_push_ok = push & ~full;
  assign w_pop_ok  = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; contents are meaningless while empty.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule

// File: rtl/mmio_port_responder.sv
// Memory-mapped I/O responder beside DataMemory on the MIPS data bus.
//   clk, reset   : system clock, async active-low reset
//   bus (slave)  : Address/WriteData/MemWrite/MemRead in, ReadData out (combinational)
//   PortIn       : asynchronous board input pins
//   PortOut      : output port register
//   tx_data/tx_valid/tx_ready : TX FIFO stream head
// Window of four word registers: PORT_OUT, PORT_IN, STATUS (W1C), TX_DATA.
module mmio_port_responder
  import mmio_port_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1001_0040,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  mmio_port_responder_if.slave        bus,
  input  logic [7:0]                  PortIn,
  output logic [31:0]                 PortOut,
  output logic [7:0]                  tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready
);

  logic             w_hit;
  reg_sel_e         w_sel;
  logic             w_wr;
  logic             w_rd;
  logic             w_push;
  logic             w_pop;
  logic             w_clr_chg;
  logic             w_clr_ovf;
  logic             w_full;
  logic             w_empty;
  logic [7:0]       w_dout;
  logic [CNT_W-1:0] w_count;
  logic             w_unused;

  logic [31:0] r_port_out;
  logic [7:0]  r_s1;
  logic [7:0]  r_in_sync;
  logic [7:0]  r_in_prev;
  logic        r_in_changed;
  logic        r_overflow;

  // Address decode: 16-byte window, byte lane bits ignored.
  assign w_hit     = (bus.Address[31:4] == BASE_ADDR[31:4]);
  assign w_sel     = reg_sel_e'(bus.Address[3:2]);
  assign w_wr      = bus.MemWrite & w_hit;
  assign w_rd      = bus.MemRead & w_hit;
  assign w_push    = w_wr & (w_sel == REG_TX_DATA);
  assign w_clr_chg = w_wr & (w_sel == REG_STATUS) & bus.WriteData[ST_IN_CHANGED];
  assign w_clr_ovf = w_wr & (w_sel == REG_STATUS) & bus.WriteData[ST_OVERFLOW];
  assign w_pop     = tx_valid & tx_ready;
  assign w_unused  = ^bus.Address[1:0];

  // Output port register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_port_out <= '0;
    end else if (w_wr && (w_sel == REG_PORT_OUT)) begin
      r_port_out <= bus.WriteData;
    end
  end

  // Two-flop synchronizer plus one history stage for change detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1      <= '0;
      r_in_sync <= '0;
      r_in_prev <= '0;
    end else begin
      r_s1      <= PortIn;
      r_in_sync <= r_s1;
      r_in_prev <= r_in_sync;
    end
  end

  // Sticky flags: a new set event beats a simultaneous W1C clear.
  // Overflow is judged on the pre-edge full flag, so a same-cycle pop does not rescue the push.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_in_changed <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_in_changed <= (r_in_sync != r_in_prev) | (r_in_changed & ~w_clr_chg);
      r_overflow   <= (w_push & w_full) | (r_overflow & ~w_clr_ovf);
    end
  end

  mmio_port_responder_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .din   (bus.WriteData[7:0]),
    .pop   (w_pop),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  assign PortOut  = r_port_out;
  assign tx_data  = w_dout;
  assign tx_valid = ~w_empty;

  // Combinational read mux; side-effect free and zero on miss.
  always_comb begin
    bus.ReadData = '0;
    if (w_rd) begin
      case (w_sel)
        REG_PORT_OUT: bus.ReadData = r_port_out;
        REG_PORT_IN:  bus.ReadData = {24'b0, r_in_sync};
        REG_STATUS:   bus.ReadData = pack_status(r_in_changed, w_full, w_empty,
                                                 r_overflow, 8'(w_count));
        default:      bus.ReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_port_responder.sv
// Self-checking bench for mmio_port_responder: register vector table,
// directed multi-cycle sequences and a randomized run against a queue model.
module tb_mmio_port_responder;

  localparam logic [31:0] BASE  = 32'h1001_0040;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  PortIn = 8'h00;
  logic        tx_ready = 1'b0;
  logic [31:0] PortOut;
  logic [7:0]  tx_data;
  logic        tx_valid;

  int checks = 0;
  int fails  = 0;

  mmio_port_responder_if bus();

  mmio_port_responder #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (3)
  ) dut (
    .clk      (clk),
    .reset    (rst_n),
    .bus      (bus),
    .PortIn   (PortIn),
    .PortOut  (PortOut),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] m_port_out;
  logic [7:0]  m_q[$];
  logic [7:0]  m_hist[$];   // PortIn sampled at recent edges, newest first
  bit          m_chg;
  bit          m_ovf;

  function automatic bit m_hit(input logic [31:0] a);
    return (a / 32'd16) == (BASE / 32'd16);
  endfunction

  task automatic m_reset();
    m_port_out = '0;
    m_q.delete();
    m_hist = '{8'h00, 8'h00, 8'h00};
    m_chg = 1'b0;
    m_ovf = 1'b0;
  endtask

  function automatic logic [31:0] m_status();
    int unsigned n;
    int unsigned v;
    n = m_q.size();
    v = (m_chg ? 1 : 0) + (n == DEPTH ? 2 : 0) + (n == 0 ? 4 : 0) + (m_ovf ? 8 : 0) + 16 * n;
    return v;
  endfunction

  function automatic logic [31:0] m_read();
    int unsigned off;
    if (!bus.MemRead || !m_hit(bus.Address)) return 32'h0;
    off = bus.Address % 32'd16;
    case (off / 4)
      0:       return m_port_out;
      1:       return 32'(m_hist[1]);
      2:       return m_status();
      default: return 32'h0;
    endcase
  endfunction

  // Advance the model across one rising edge using the current bus inputs.
  task automatic m_step();
    int unsigned off;
    int unsigned n;
    bit wr_hit, push, w1c, new_chg, new_ovf;
    off     = bus.Address % 32'd16;
    wr_hit  = bus.MemWrite && m_hit(bus.Address);
    push    = wr_hit && (off / 4 == 3);
    w1c     = wr_hit && (off / 4 == 2);
    n       = m_q.size();
    new_chg = (m_hist[1] != m_hist[2]) || (m_chg && !(w1c && bus.WriteData[0]));
    new_ovf = (push && n == DEPTH) || (m_ovf && !(w1c && bus.WriteData[3]));
    if (n > 0 && tx_ready) void'(m_q.pop_front());
    if (push && n < DEPTH) m_q.push_back(bus.WriteData[7:0]);
    if (wr_hit && off / 4 == 0) m_port_out = bus.WriteData;
    m_hist.push_front(PortIn);
    void'(m_hist.pop_back());
    m_chg = new_chg;
    m_ovf = new_ovf;
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [31:0] addr,
                       input logic [31:0] wd);
    bus.MemWrite  = wr;
    bus.MemRead   = rd;
    bus.Address   = addr;
    bus.WriteData = wd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Called just after a falling edge; returns just after the next one.
  task automatic tick();
    if (rst_n) m_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    drive(1'b0, 1'b1, addr, 32'h0);
    #1;
    chk(name, bus.ReadData, exp);
  endtask

  task automatic push_byte(input logic [7:0] b);
    drive(1'b1, 1'b0, BASE + 32'hC, {24'h0, b});
    tick();
  endtask

  task automatic w1c(input logic [31:0] bits);
    drive(1'b1, 1'b0, BASE + 32'h8, bits);
    tick();
  endtask

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic [31:0] exp_po;
  } vec_t;

  vec_t        vec[12];
  logic [7:0]  got[$];
  logic [7:0]  exp_b;

  initial begin
    idle();
    m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // ---- register access table (PortIn=0, tx_ready=0) ----
    vec[0]  = '{1'b0, 1'b1, BASE + 32'h08, 32'h0,         32'h0000_0004, 32'h0};
    vec[1]  = '{1'b1, 1'b0, BASE + 32'h00, 32'hDEAD_BEEF, 32'h0,         32'hDEAD_BEEF};
    vec[2]  = '{1'b0, 1'b1, BASE + 32'h00, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vec[3]  = '{1'b1, 1'b1, BASE + 32'h20, 32'h1234_5678, 32'h0,         32'hDEAD_BEEF};
    vec[4]  = '{1'b1, 1'b1, BASE + 32'h00, 32'h0000_00FF, 32'hDEAD_BEEF, 32'h0000_00FF};
    vec[5]  = '{1'b0, 1'b1, BASE + 32'h03, 32'h0,         32'h0000_00FF, 32'h0000_00FF};
    vec[6]  = '{1'b1, 1'b1, BASE + 32'h04, 32'hFFFF_FFFF, 32'h0,         32'h0000_00FF};
    vec[7]  = '{1'b0, 1'b1, BASE + 32'h04, 32'h0,         32'h0,         32'h0000_00FF};
    vec[8]  = '{1'b0, 1'b1, BASE + 32'h0C, 32'h0,         32'h0,         32'h0000_00FF};
    vec[9]  = '{1'b0, 1'b1, BASE + 32'h10, 32'h0,         32'h0,         32'h0000_00FF};
    vec[10] = '{1'b1, 1'b1, BASE + 32'h08, 32'hFFFF_FFFF, 32'h0000_0004, 32'h0000_00FF};
    vec[11] = '{1'b0, 1'b0, BASE + 32'h00, 32'h0,         32'h0,         32'h0000_00FF};
    foreach (vec[i]) begin
      drive(vec[i].wr, vec[i].rd, vec[i].addr, vec[i].wd);
      #1;
      chk($sformatf("vec%0d_rdata", i), bus.ReadData, vec[i].exp_rd);
      tick();
      chk($sformatf("vec%0d_portout", i), PortOut, vec[i].exp_po);
    end
    idle();

    // ---- input synchronizer latency and in_changed W1C ----
    PortIn = 8'hA5;
    tick();
    rd_chk("pin_after1", BASE + 32'h4, 32'h0);
    tick();
    rd_chk("pin_after2", BASE + 32'h4, 32'hA5);
    rd_chk("chg_not_yet", BASE + 32'h8, 32'h04);
    tick();
    rd_chk("chg_set", BASE + 32'h8, 32'h05);
    w1c(32'h1);
    rd_chk("chg_cleared", BASE + 32'h8, 32'h04);
    PortIn = 8'h5A;
    idle();
    tick();
    tick();
    w1c(32'h1);
    rd_chk("chg_set_wins", BASE + 32'h8, 32'h05);
    w1c(32'h1);
    rd_chk("chg_clear2", BASE + 32'h8, 32'h04);

    // ---- fill past full, then drain ----
    tx_ready = 1'b0;
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44); push_byte(8'h55);
    rd_chk("full_status", BASE + 32'h8, 32'h4A);
    chk("full_head", 32'(tx_data), 32'h11);
    idle();
    tx_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_b = 8'h11 * 8'(k + 1);
      chk($sformatf("drain%0d_valid", k), 32'(tx_valid), 32'h1);
      chk($sformatf("drain%0d_data", k), 32'(tx_data), 32'(exp_b));
      tick();
    end
    chk("drain_empty", 32'(tx_valid), 32'h0);
    tx_ready = 1'b0;
    w1c(32'h8);
    rd_chk("ovf_cleared", BASE + 32'h8, 32'h04);

    // ---- push while full with a simultaneous pop ----
    push_byte(8'hA1); push_byte(8'hA2); push_byte(8'hA3); push_byte(8'hA4);
    tx_ready = 1'b1;
    push_byte(8'h66);
    tx_ready = 1'b0;
    rd_chk("fullpop_status", BASE + 32'h8, 32'h38);
    chk("fullpop_head", 32'(tx_data), 32'hA2);
    idle();
    tx_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_b = 8'hA2 + 8'(k);
      chk($sformatf("fp_drain%0d", k), 32'(tx_data), 32'(exp_b));
      tick();
    end
    chk("fp_empty", 32'(tx_valid), 32'h0);
    tx_ready = 1'b0;
    w1c(32'h8);

    // ---- streaming: push every cycle with tx_ready held ----
    tx_ready = 1'b1;
    got.delete();
    for (int k = 0; k < 10; k++) begin
      if (tx_valid) got.push_back(tx_data);
      push_byte(8'h30 + 8'(k));
    end
    idle();
    if (tx_valid) got.push_back(tx_data);
    tick();
    chk("stream_count", 32'(got.size()), 32'd10);
    foreach (got[k]) chk($sformatf("stream%0d", k), 32'(got[k]), 32'h30 + 32'(k));
    rd_chk("stream_status", BASE + 32'h8, 32'h04);
    tx_ready = 1'b0;

    // ---- reset in the middle of activity ----
    idle();
    drive(1'b1, 1'b0, BASE, 32'h55AA_55AA);
    tick();
    push_byte(8'h77); push_byte(8'h88);
    PortIn = 8'h3C;
    idle();
    tick();
    rst_n = 1'b0;
    m_reset();
    PortIn = 8'h00;
    rd_chk("rst_status", BASE + 32'h8, 32'h04);
    chk("rst_portout", PortOut, 32'h0);
    chk("rst_txvalid", 32'(tx_valid), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    rd_chk("post_rst_status", BASE + 32'h8, 32'h04);
    idle();

    // ---- randomized run against the model ----
    for (int k = 0; k < 400; k++) begin
      int unsigned sel;
      logic [31:0] a;
      sel = $urandom_range(0, 9);
      if (sel < 8)       a = BASE + $urandom_range(0, 15);
      else if (sel == 8) a = BASE + 32'h20;
      else               a = $urandom;
      drive(($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), a, $urandom);
      tx_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) PortIn = 8'($urandom);
      #1;
      chk("rnd_rdata", bus.ReadData, m_read());
      chk("rnd_portout", PortOut, m_port_out);
      chk("rnd_txvalid", 32'(tx_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) chk("rnd_txdata", 32'(tx_data), 32'(m_q[0]));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
